// File: rtl/mc_pkg.sv
// -----------------------------------------------------------------------------
// mc_pkg
// Shared constants and helpers for the Monte Carlo path feeder.
//   N, DAY        : default paths per day / time steps per path
//   PRICE_W       : price width (12 bits, unsigned)
//   S0            : default initial price of every path
//   DEFAULT_SEED  : LFSR seed substituted when a zero seed is requested
//   LFSR_TAPS     : Fibonacci tap mask for taps 16,14,13,11 (bits 15,13,12,10)
//   mc_state_e    : feeder FSM encoding
//   price_step()  : one random-walk step with clamping to 0..2^PRICE_W-1
// -----------------------------------------------------------------------------
package mc_pkg;

  localparam int N       = 256;
  localparam int DAY     = 8;
  localparam int PRICE_W = 12;

  localparam logic [PRICE_W-1:0] S0        = 12'd1000;
  localparam logic [PRICE_W-1:0] PRICE_MAX = '1;

  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GEN    = 2'd1,
    ST_LAUNCH = 2'd2,
    ST_STREAM = 2'd3
  } mc_state_e;

  // delta = draw - 32, range -32..+31. The sum carries two spare bits above
  // the price so that 4095 + 31 does not wrap negative before the clamp.
  function automatic logic [PRICE_W-1:0] price_step(
    input logic [PRICE_W-1:0] price,
    input logic [5:0]         draw
  );
    logic signed [PRICE_W+1:0] sum;
    sum = $signed({2'b00, price}) + $signed({8'd0, draw}) - 14'sd32;
    if (sum < 14'sd0) begin
      price_step = '0;
    end else if (sum > $signed({2'b00, PRICE_MAX})) begin
      price_step = PRICE_MAX;
    end else begin
      price_step = sum[PRICE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/mc_path_feeder_lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16
// 16-bit Fibonacci LFSR, shifting left with the feedback bit entering bit 0.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, loads RESET_SEED
//   load  : load seed (caller guarantees a non-zero value)
//   seed  : value loaded on load
//   en    : advance one step (load has priority)
//   q     : current LFSR state
// -----------------------------------------------------------------------------
module lfsr16
  import mc_pkg::*;
#(
  parameter logic [15:0] RESET_SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        en,
  output logic [15:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_SEED;
    end else if (load) begin
      q <= seed;
    end else if (en) begin
      q <= {q[14:0], ^(q & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/mc_path_feeder.sv
// -----------------------------------------------------------------------------
// mc_path_feeder
// Upstream stage of the Monte Carlo pricing core. Generates N random-walk
// price paths of DAY steps into an internal DAY x N memory, launches the core,
// then streams one day at a time (day DAY-1 down to 0), path by path.
//
// Ports:
//   clk, rst     : clock (rising edge), synchronous active-high reset
//   gen_start    : start generation + pricing, honoured only when idle
//   seed         : LFSR seed sampled with an accepted gen_start (0 = default)
//   busy         : high in every state except IDLE
//   core_start   : one-cycle pulse to the core's start input
//   core_resend  : core asks for the (re)start of a day's stream
//   core_valid   : core has its result; ends the run
//   path         : price presented to the core (0 outside STREAM)
//   cur_day      : day being streamed (0 outside STREAM)
//   done         : one-cycle pulse after core_valid is accepted
//   state_dbg    : FSM state
//
// Handshake: core_start and done are single-cycle registered pulses.
// core_resend and core_valid are sampled every cycle while streaming, each
// high cycle is one event; core_valid wins when both are high. A resend
// redirects path combinationally to element 0 of its target day in the same
// cycle and element 1 follows in the next cycle.
// -----------------------------------------------------------------------------
module mc_path_feeder #(
  parameter int                           N            = mc_pkg::N,
  parameter int                           DAY          = mc_pkg::DAY,
  parameter logic [mc_pkg::PRICE_W-1:0]   S0           = mc_pkg::S0,
  parameter logic [15:0]                  DEFAULT_SEED = mc_pkg::DEFAULT_SEED
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       gen_start,
  input  logic [15:0]                seed,
  output logic                       busy,
  output logic                       core_start,
  input  logic                       core_resend,
  input  logic                       core_valid,
  output logic [mc_pkg::PRICE_W-1:0] path,
  output logic [2:0]                 cur_day,
  output logic                       done,
  output mc_pkg::mc_state_e          state_dbg
);

  localparam int PW    = mc_pkg::PRICE_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int DAY_W = (DAY > 1) ? $clog2(DAY) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [DAY_W-1:0] LAST_DAY = DAY_W'(DAY - 1);

  mc_pkg::mc_state_e state;

  // During GEN idx/day act as path counter p and step counter d; during
  // STREAM they are the read pointer and the day being streamed.
  logic [IDX_W-1:0] idx;
  logic [DAY_W-1:0] day;
  logic             replay;
  logic [PW-1:0]    price;

  logic [PW-1:0]    mem [DAY][N];

  logic [15:0]      lfsr_q;
  logic [15:0]      seed_eff;
  logic             gen_load;
  logic             gen_en;
  logic [PW-1:0]    gen_next;
  logic             unused_lfsr_hi;

  logic             resend_take;
  logic [DAY_W-1:0] target_day;
  logic [DAY_W-1:0] rd_day;
  logic [IDX_W-1:0] rd_idx;

  // ---------------------------------------------------------------------------
  // Random source
  // ---------------------------------------------------------------------------
  assign seed_eff = (seed == 16'd0) ? DEFAULT_SEED : seed;
  assign gen_load = (state == mc_pkg::ST_IDLE) && gen_start;
  assign gen_en   = (state == mc_pkg::ST_GEN);

  lfsr16 #(
    .RESET_SEED (DEFAULT_SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (gen_load),
    .seed (seed_eff),
    .en   (gen_en),
    .q    (lfsr_q)
  );

  // Only the low six bits form the draw.
  assign unused_lfsr_hi = ^lfsr_q[15:6];
  assign gen_next       = mc_pkg::price_step(price, lfsr_q[5:0]);

  // ---------------------------------------------------------------------------
  // Resend target and combinational read
  // ---------------------------------------------------------------------------
  assign resend_take = (state == mc_pkg::ST_STREAM) && core_resend && !core_valid;

  // A new-day request while already on day 0 stays on day 0.
  always_comb begin
    target_day = day;
    if (replay && (day != '0)) begin
      target_day = day - 1'b1;
    end
  end

  assign rd_day = resend_take ? target_day : day;
  assign rd_idx = resend_take ? '0 : idx;

  assign path      = (state == mc_pkg::ST_STREAM) ? mem[rd_day][rd_idx] : '0;
  assign cur_day   = (state == mc_pkg::ST_STREAM) ? 3'(day) : 3'd0;
  assign busy      = (state != mc_pkg::ST_IDLE);
  assign state_dbg = state;

  // ---------------------------------------------------------------------------
  // Path memory (not reset; contents only meaningful after GEN)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (state == mc_pkg::ST_GEN) begin
      mem[day][idx] <= gen_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= mc_pkg::ST_IDLE;
      idx        <= '0;
      day        <= '0;
      replay     <= 1'b0;
      price      <= S0;
      core_start <= 1'b0;
      done       <= 1'b0;
    end else begin
      core_start <= 1'b0;
      done       <= 1'b0;
      case (state)
        mc_pkg::ST_IDLE: begin
          if (gen_start) begin
            idx   <= '0;
            day   <= '0;
            price <= S0;
            state <= mc_pkg::ST_GEN;
          end
        end

        mc_pkg::ST_GEN: begin
          if (day == LAST_DAY) begin
            // Path finished: restart the walk from S0 for the next path.
            day   <= '0;
            price <= S0;
            if (idx == LAST_IDX) begin
              idx        <= '0;
              day        <= LAST_DAY;
              replay     <= 1'b0;
              core_start <= 1'b1;
              state      <= mc_pkg::ST_LAUNCH;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            day   <= day + 1'b1;
            price <= gen_next;
          end
        end

        mc_pkg::ST_LAUNCH: begin
          state <= mc_pkg::ST_STREAM;
        end

        mc_pkg::ST_STREAM: begin
          if (core_valid) begin
            done  <= 1'b1;
            state <= mc_pkg::ST_IDLE;
          end else if (core_resend) begin
            // Element 0 is presented this cycle, so continue at element 1.
            idx <= IDX_W'(1);
            if (replay) begin
              day    <= target_day;
              replay <= 1'b0;
            end else begin
              replay <= 1'b1;
            end
          end else if (idx != LAST_IDX) begin
            idx <= idx + 1'b1;
          end
        end

        default: begin
          state <= mc_pkg::ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc_path_feeder.sv
// -----------------------------------------------------------------------------
// tb_mc_path_feeder
// Small instances (N=4, DAY=2) with hand-computed memory contents drive a
// per-cycle vector table; a full-size instance (N=256, DAY=8) is exercised
// against a reference walk through a complete pricing run.
// -----------------------------------------------------------------------------
module tb_mc_path_feeder;
  import mc_pkg::*;

  localparam int FN   = 256;
  localparam int FDAY = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Small instances: 0 = S0 1000, 1 = S0 10, 2 = S0 4090
  logic        gen_start_s;
  logic [15:0] seed_s [3];
  logic        resend_s;
  logic        valid_s;
  logic        busy_s [3];
  logic        core_start_s [3];
  logic        done_s [3];
  logic [11:0] path_s [3];
  logic [2:0]  cur_day_s [3];
  mc_state_e   state_s [3];

  // Full-size instance
  logic        gen_start_f;
  logic [15:0] seed_f;
  logic        resend_f;
  logic        valid_f;
  logic        busy_f;
  logic        core_start_f;
  logic        done_f;
  logic [11:0] path_f;
  logic [2:0]  cur_day_f;
  mc_state_e   state_f;

  mc_path_feeder #(.N(4), .DAY(2), .S0(12'd1000)) u_a (
    .clk(clk), .rst(rst), .gen_start(gen_start_s), .seed(seed_s[0]),
    .busy(busy_s[0]), .core_start(core_start_s[0]), .core_resend(resend_s),
    .core_valid(valid_s), .path(path_s[0]), .cur_day(cur_day_s[0]),
    .done(done_s[0]), .state_dbg(state_s[0])
  );

  mc_path_feeder #(.N(4), .DAY(2), .S0(12'd10)) u_lo (
    .clk(clk), .rst(rst), .gen_start(gen_start_s), .seed(seed_s[1]),
    .busy(busy_s[1]), .core_start(core_start_s[1]), .core_resend(resend_s),
    .core_valid(valid_s), .path(path_s[1]), .cur_day(cur_day_s[1]),
    .done(done_s[1]), .state_dbg(state_s[1])
  );

  mc_path_feeder #(.N(4), .DAY(2), .S0(12'd4090)) u_hi (
    .clk(clk), .rst(rst), .gen_start(gen_start_s), .seed(seed_s[2]),
    .busy(busy_s[2]), .core_start(core_start_s[2]), .core_resend(resend_s),
    .core_valid(valid_s), .path(path_s[2]), .cur_day(cur_day_s[2]),
    .done(done_s[2]), .state_dbg(state_s[2])
  );

  mc_path_feeder dut (
    .clk(clk), .rst(rst), .gen_start(gen_start_f), .seed(seed_f),
    .busy(busy_f), .core_start(core_start_f), .core_resend(resend_f),
    .core_valid(valid_f), .path(path_f), .cur_day(cur_day_f),
    .done(done_f), .state_dbg(state_f)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and compare helper
  // ---------------------------------------------------------------------------
  int n_cmp;
  int n_err;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference walk for the full-size instance
  // ---------------------------------------------------------------------------
  int exp_mem [FDAY][FN];

  function automatic logic [15:0] ref_lfsr(input logic [15:0] q);
    logic fb;
    fb = q[15] ^ q[13] ^ q[12] ^ q[10];
    return {q[14:0], fb};
  endfunction

  function automatic int ref_step(input int price, input logic [15:0] q);
    int v;
    v = price + int'(q[5:0]) - 32;
    if (v < 0) v = 0;
    if (v > 4095) v = 4095;
    return v;
  endfunction

  task automatic build_model(input logic [15:0] seed_in);
    logic [15:0] q;
    int price;
    q = (seed_in == 16'd0) ? 16'hACE1 : seed_in;
    for (int p = 0; p < FN; p++) begin
      price = 1000;
      for (int d = 0; d < FDAY; d++) begin
        price = ref_step(price, q);
        exp_mem[d][p] = price;
        q = ref_lfsr(q);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Full-size driver tasks
  // ---------------------------------------------------------------------------
  task automatic stream_chk(input int d, input int start_idx, input int cycles);
    int i;
    for (int k = 0; k < cycles; k++) begin
      i = start_idx + k;
      if (i > FN - 1) i = FN - 1;
      resend_f = 1'b0;
      @(negedge clk);
      chk($sformatf("stream_d%0d_i%0d_path", d, i), int'(path_f), exp_mem[d][i]);
      chk($sformatf("stream_d%0d_cur_day", d), int'(cur_day_f), d);
      @(posedge clk); #1;
    end
  endtask

  task automatic do_resend(input int target, input int cur);
    resend_f = 1'b1;
    @(negedge clk);
    chk($sformatf("resend_t%0d_path", target), int'(path_f), exp_mem[target][0]);
    chk($sformatf("resend_t%0d_cur_day", target), int'(cur_day_f), cur);
    @(posedge clk); #1;
    resend_f = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Vector table for the small instances
  // ---------------------------------------------------------------------------
  typedef struct {
    int resend;
    int valid;
    int exp_a;
    int exp_lo;
    int exp_hi;
    int exp_day;
    int exp_busy;
    int exp_done;
  } vec_t;

  vec_t vecs [18];

  int k_wait;
  int done_cnt;
  int dd;

  initial begin
    n_cmp = 0;
    n_err = 0;

    // mem (S0 1000, seed 1): d0 = 969 972 984 968, d1 = 939 948 984 936
    // mem (S0 10,   seed 1): all 0
    // mem (S0 4090, seed 3F): d0 = 4095 4095 4095 4059, d1 = 4095 4095 4095 4030
    vecs[0]  = '{0, 0, 939, 0, 4095, 1, 1, 0};
    vecs[1]  = '{0, 0, 948, 0, 4095, 1, 1, 0};
    vecs[2]  = '{0, 0, 984, 0, 4095, 1, 1, 0};
    vecs[3]  = '{0, 0, 936, 0, 4030, 1, 1, 0};
    vecs[4]  = '{0, 0, 936, 0, 4030, 1, 1, 0};  // held at last element
    vecs[5]  = '{1, 0, 939, 0, 4095, 1, 1, 0};  // replay day 1
    vecs[6]  = '{0, 0, 948, 0, 4095, 1, 1, 0};
    vecs[7]  = '{1, 0, 969, 0, 4095, 1, 1, 0};  // new day 0
    vecs[8]  = '{0, 0, 972, 0, 4095, 0, 1, 0};
    vecs[9]  = '{0, 0, 984, 0, 4095, 0, 1, 0};
    vecs[10] = '{0, 0, 968, 0, 4059, 0, 1, 0};
    vecs[11] = '{0, 0, 968, 0, 4059, 0, 1, 0};
    vecs[12] = '{1, 0, 969, 0, 4095, 0, 1, 0};  // replay day 0
    vecs[13] = '{1, 0, 969, 0, 4095, 0, 1, 0};  // illegal new day, stays 0
    vecs[14] = '{1, 0, 969, 0, 4095, 0, 1, 0};  // replay again
    vecs[15] = '{1, 1, 972, 0, 4095, 0, 1, 0};  // valid beats resend
    vecs[16] = '{0, 0, 0,   0, 0,    0, 0, 1};
    vecs[17] = '{0, 0, 0,   0, 0,    0, 0, 0};

    // Clock/reset
    rst         = 1'b1;
    gen_start_s = 1'b0;
    resend_s    = 1'b0;
    valid_s     = 1'b0;
    for (int i = 0; i < 3; i++) seed_s[i] = 16'd0;
    gen_start_f = 1'b0;
    seed_f      = 16'd0;
    resend_f    = 1'b0;
    valid_f     = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy_f), 0);
    chk("rst_core_start", int'(core_start_f), 0);
    chk("rst_done", int'(done_f), 0);
    chk("rst_path", int'(path_f), 0);
    chk("rst_cur_day", int'(cur_day_f), 0);
    chk("rst_state", int'(state_f), int'(ST_IDLE));
    chk("rst_state_small", int'(state_s[0]), int'(ST_IDLE));
    @(posedge clk); #1;
    rst = 1'b0;

    // -------------------------------------------------------------------------
    // Small instances: generation golden, clamp, stream order, resend protocol
    // -------------------------------------------------------------------------
    @(posedge clk); #1;
    seed_s[0]   = 16'h0001;
    seed_s[1]   = 16'h0001;
    seed_s[2]   = 16'h003F;
    gen_start_s = 1'b1;
    @(posedge clk); #1;
    gen_start_s = 1'b0;

    k_wait = 0;
    for (int w = 0; w < 64; w++) begin
      @(negedge clk);
      if (core_start_s[0]) break;
      k_wait++;
    end
    chk("small_launch_cycles", k_wait, 8);
    chk("small_core_start_a", int'(core_start_s[0]), 1);
    chk("small_core_start_lo", int'(core_start_s[1]), 1);
    chk("small_core_start_hi", int'(core_start_s[2]), 1);
    chk("small_launch_state", int'(state_s[0]), int'(ST_LAUNCH));
    @(posedge clk); #1;

    for (int i = 0; i < 18; i++) begin
      resend_s = (vecs[i].resend != 0);
      valid_s  = (vecs[i].valid != 0);
      @(negedge clk);
      chk($sformatf("vec%0d_path_a", i), int'(path_s[0]), vecs[i].exp_a);
      chk($sformatf("vec%0d_path_lo", i), int'(path_s[1]), vecs[i].exp_lo);
      chk($sformatf("vec%0d_path_hi", i), int'(path_s[2]), vecs[i].exp_hi);
      chk($sformatf("vec%0d_cur_day", i), int'(cur_day_s[0]), vecs[i].exp_day);
      chk($sformatf("vec%0d_busy", i), int'(busy_s[0]), vecs[i].exp_busy);
      chk($sformatf("vec%0d_done", i), int'(done_s[0]), vecs[i].exp_done);
      chk($sformatf("vec%0d_core_start", i), int'(core_start_s[0]), 0);
      @(posedge clk); #1;
    end
    resend_s = 1'b0;
    valid_s  = 1'b0;

    // -------------------------------------------------------------------------
    // Full-size instance: reset mid-GEN
    // -------------------------------------------------------------------------
    seed_f      = 16'hBEEF;
    gen_start_f = 1'b1;
    @(posedge clk); #1;
    gen_start_f = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("midgen_busy", int'(busy_f), 1);
    chk("midgen_state", int'(state_f), int'(ST_GEN));
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy_f), 0);
    chk("abort_core_start", int'(core_start_f), 0);
    chk("abort_done", int'(done_f), 0);
    chk("abort_path", int'(path_f), 0);
    chk("abort_state", int'(state_f), int'(ST_IDLE));

    // -------------------------------------------------------------------------
    // Full-size instance: complete run with the default seed
    // -------------------------------------------------------------------------
    build_model(16'h0000);
    @(posedge clk); #1;
    seed_f      = 16'h0000;
    gen_start_f = 1'b1;
    @(posedge clk); #1;
    gen_start_f = 1'b0;

    k_wait = 0;
    for (int w = 0; w < 2200; w++) begin
      @(negedge clk);
      if (core_start_f) break;
      k_wait++;
    end
    chk("full_launch_cycles", k_wait, FN * FDAY);
    chk("full_core_start", int'(core_start_f), 1);
    @(posedge clk); #1;

    // Day 7 in path order, then held on the last element
    stream_chk(7, 0, FN + 3);

    // gen_start while streaming must be ignored
    gen_start_f = 1'b1;
    seed_f      = 16'h1234;
    @(negedge clk);
    chk("ignore_gen_busy", int'(busy_f), 1);
    chk("ignore_gen_path", int'(path_f), exp_mem[7][FN-1]);
    @(posedge clk); #1;
    gen_start_f = 1'b0;
    @(negedge clk);
    chk("ignore_gen_state", int'(state_f), int'(ST_STREAM));
    @(posedge clk); #1;
    stream_chk(7, FN - 1, 2);

    // 15 resends: replay/new-day alternation down to day 0, then a replay
    dd = 7;
    for (int r = 0; r < 2 * FDAY - 1; r++) begin
      if ((r % 2) == 0) begin
        do_resend(dd, dd);
        stream_chk(dd, 1, 4);
      end else begin
        do_resend(dd - 1, dd);
        dd = dd - 1;
        stream_chk(dd, 1, 4);
      end
    end

    // Core reports valid
    valid_f = 1'b1;
    @(negedge clk);
    chk("valid_cycle_done", int'(done_f), 0);
    chk("valid_cycle_busy", int'(busy_f), 1);
    @(posedge clk); #1;
    valid_f  = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done_f) done_cnt++;
      if (k == 0) chk("done_pulse", int'(done_f), 1);
      chk($sformatf("post_busy_%0d", k), int'(busy_f), 0);
      chk($sformatf("post_path_%0d", k), int'(path_f), 0);
      @(posedge clk); #1;
    end
    chk("done_count", done_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
